// File: rtl/mrr_pathway_packet_mux.sv
// rtl/mrr_pathway_packet_mux.sv - packet-level round-robin merge of per-pathway decoded streams
module mrr_pathway_packet_mux #(
   parameter int NUM_PATHWAYS       = 4,
   parameter int DATA_WIDTH         = 32,
   parameter int PATHWAY_IDX_WIDTH  = 2,
   parameter int MAX_PKT_WORDS_LOG2 = 10
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
   input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
   input  logic [NUM_PATHWAYS-1:0]            i_tlast,
   output logic [NUM_PATHWAYS-1:0]            i_tready,
   output logic [DATA_WIDTH-1:0]              o_tdata,
   output logic                               o_tvalid,
   output logic                               o_tlast,
   input  logic                               o_tready,
   output logic [PATHWAY_IDX_WIDTH-1:0]       o_pathway,
   output logic [15:0]                        trunc_count
);

   typedef enum logic [1:0] {IDLE, TAG, DATA, FLUSH} state_t;

   state_t                          state;
   logic [PATHWAY_IDX_WIDTH-1:0]    sel;
   logic [PATHWAY_IDX_WIDTH-1:0]    last_grant;
   logic [MAX_PKT_WORDS_LOG2-1:0]   wcnt;
   logic [15:0]                     seq [NUM_PATHWAYS];
   logic [DATA_WIDTH-1:0]           tag_word;
   logic [DATA_WIDTH-1:0]           in_data [NUM_PATHWAYS];

   logic                            arb_found;
   logic [PATHWAY_IDX_WIDTH-1:0]    arb_sel;
   logic [PATHWAY_IDX_WIDTH-1:0]    cand;
   logic [31:0]                     tag32;
   logic                            wcnt_last;
   logic                            in_hs;

   genvar g;
   generate
      for (g = 0; g < NUM_PATHWAYS; g++) begin : g_unpack
         assign in_data[g] = i_tdata[DATA_WIDTH*(g+1)-1 -: DATA_WIDTH];
      end
   endgenerate

   // Round-robin search starts one past the previous grant and wraps.
   always_comb begin
      arb_found = 1'b0;
      arb_sel   = '0;
      cand      = last_grant;
      for (int k = 0; k < NUM_PATHWAYS; k++) begin
         cand = (cand == PATHWAY_IDX_WIDTH'(NUM_PATHWAYS-1)) ? '0 : cand + 1'b1;
         if (!arb_found && i_tvalid[cand]) begin
            arb_found = 1'b1;
            arb_sel   = cand;
         end
      end
   end

   assign tag32     = {8'hA5, 8'(arb_sel), seq[arb_sel]};
   assign wcnt_last = (wcnt == {MAX_PKT_WORDS_LOG2{1'b1}});
   assign in_hs     = i_tvalid[sel] && o_tready;

   always_comb begin
      o_tdata  = '0;
      o_tvalid = 1'b0;
      o_tlast  = 1'b0;
      i_tready = '0;
      case (state)
         TAG: begin
            o_tdata  = tag_word;
            o_tvalid = 1'b1;
         end
         DATA: begin
            o_tdata       = in_data[sel];
            o_tvalid      = i_tvalid[sel];
            o_tlast       = i_tlast[sel] | wcnt_last;
            i_tready[sel] = o_tready;
         end
         FLUSH: i_tready[sel] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel         <= '0;
         last_grant  <= PATHWAY_IDX_WIDTH'(NUM_PATHWAYS-1);
         o_pathway   <= '0;
         wcnt        <= '0;
         tag_word    <= '0;
         trunc_count <= '0;
         for (int p = 0; p < NUM_PATHWAYS; p++) seq[p] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  sel        <= arb_sel;
                  last_grant <= arb_sel;
                  o_pathway  <= arb_sel;
                  tag_word   <= DATA_WIDTH'(tag32);
                  state      <= TAG;
               end
            end
            TAG: begin
               if (o_tready) begin
                  wcnt  <= '0;
                  state <= DATA;
               end
            end
            DATA: begin
               if (in_hs) begin
                  wcnt <= wcnt + 1'b1;
                  if (i_tlast[sel]) begin
                     seq[sel] <= seq[sel] + 16'd1;
                     state    <= IDLE;
                  end else if (wcnt_last) begin
                     if (trunc_count != 16'hFFFF) trunc_count <= trunc_count + 16'd1;
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               // Remainder of an over-length packet is drained without being forwarded.
               if (i_tvalid[sel] && i_tlast[sel]) begin
                  seq[sel] <= seq[sel] + 16'd1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
